// File: rtl/serial_bcd_correct_pkg.sv
// Shared constants and types for the bit-serial BCD correction stage.
package serial_bcd_correct_pkg;

  localparam int DIGIT_BITS = 4;
  localparam logic [DIGIT_BITS-1:0] BCD_ADD_CORR = 4'd6;
  localparam logic [DIGIT_BITS-1:0] BCD_SUB_CORR = 4'd10;

  // One assembled digit as it leaves the serial adder: binary carry plus nibble.
  typedef struct packed {
    logic                  co3;
    logic [DIGIT_BITS-1:0] acc;
  } raw_digit_t;

  // Width of a counter that must hold 0..value-1 (at least one bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_bcd_correct_if.sv
// Serial datapath link between the arithmetic unit (master) and the
// decimal-correction stage (slave).
interface serial_bcd_correct_if;

  logic sync;
  logic ws;
  logic sub;
  logic fa_sum;
  logic fa_co;
  logic fa_ci;
  logic add_en;
  logic res_bit;
  logic carry;

  modport master (
    output sync, ws, sub, fa_sum, fa_co,
    input  fa_ci, add_en, res_bit, carry
  );

  modport slave (
    input  sync, ws, sub, fa_sum, fa_co,
    output fa_ci, add_en, res_bit, carry
  );

endinterface

// File: rtl/serial_bcd_correct_digit.sv
// Combinational BCD correction of one assembled digit.
// Add: binary sums above 9 get +6 and raise the decimal carry.
// Sub: a missing binary carry means borrow, fixed with +10 (mod 16).
// Out of window the nibble passes through untouched.
module bcd_digit_correct
  import serial_bcd_correct_pkg::*;
(
  input  raw_digit_t            raw,
  input  logic                  sub,
  input  logic                  win,
  output logic [DIGIT_BITS-1:0] dig,
  output logic                  dc
);

  logic [DIGIT_BITS:0] s;

  assign s = {raw.co3, raw.acc};

  // Select corrected digit and decimal carry/no-borrow.
  always_comb begin
    dig = raw.acc;
    dc  = 1'b0;
    if (win) begin
      if (sub) begin
        if (raw.co3) dc = 1'b1;
        else         dig = raw.acc + BCD_SUB_CORR;
      end else if (s > 5'd9) begin
        dig = raw.acc + BCD_ADD_CORR;
        dc  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bcd_correct.sv
// Decimal-correction and carry sequencing behind the serial full adder.
// Assembles each digit LSB first, corrects it at the digit's last bit and
// replays it on res_bit during the following four clocks.
module serial_bcd_correct
  import serial_bcd_correct_pkg::*;
#(
  parameter int Digits = 14
)
(
  input  logic             clk,
  input  logic             rst,
  serial_bcd_correct_if.slave bus
);

  localparam int WordBits = DIGIT_BITS * Digits;
  localparam int CntW     = clog2(WordBits);
  localparam logic [CntW-1:0] LastBit = CntW'(WordBits - 1);

  logic [CntW-1:0]       bcnt;
  logic [1:0]            dpos;
  // Only the first three sum bits are stored; the fourth is taken live.
  logic [2:0]            acc;
  logic [DIGIT_BITS-1:0] out_sr;
  logic                  c_bin;
  logic                  c_dec;
  logic                  win_d;
  logic                  carry_q;
  logic                  resync;
  raw_digit_t            raw;
  logic [DIGIT_BITS-1:0] dig;
  logic                  dc;

  assign dpos = bcnt[1:0];

  // A sync that does not land on a digit boundary abandons the partial digit.
  assign resync = bus.sync && (dpos != 2'd3);

  assign bus.add_en  = (dpos == 2'd0) ? bus.ws : win_d;
  assign bus.res_bit = out_sr[0];
  assign bus.carry   = carry_q;

  assign raw.co3 = bus.fa_co;
  assign raw.acc = {bus.fa_sum, acc};

  bcd_digit_correct u_corr (
    .raw (raw),
    .sub (bus.sub),
    .win (win_d),
    .dig (dig),
    .dc  (dc)
  );

  // Adder carry-in: window start seeds with sub, later digits chain the decimal carry.
  always_comb begin
    bus.fa_ci = c_bin;
    if (dpos == 2'd0) begin
      if (!bus.add_en) bus.fa_ci = 1'b0;
      else if (!win_d) bus.fa_ci = bus.sub;
      else             bus.fa_ci = c_dec;
    end
  end

  // Bit position within the word, realigned by sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              bcnt <= '0;
    else if (bus.sync || bcnt == LastBit) bcnt <= '0;
    else                                  bcnt <= bcnt + 1'b1;
  end

  // Digit assembly, correction load, output shifting and carry flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      out_sr  <= '0;
      c_bin   <= 1'b0;
      c_dec   <= 1'b0;
      win_d   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      c_bin <= resync ? 1'b0 : bus.fa_co;
      if (resync) begin
        acc   <= '0;
        win_d <= 1'b0;
      end else begin
        acc <= {bus.fa_sum, acc[2:1]};
        if (dpos == 2'd0) win_d <= bus.ws;
      end
      if (dpos == 2'd3) begin
        out_sr <= dig;
        c_dec  <= dc;
        if (win_d) carry_q <= dc;
      end else begin
        out_sr <= {1'b0, out_sr[DIGIT_BITS-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_serial_bcd_correct.sv
// Bench: serial full adder model plus x/y shifters around serial_bcd_correct.
module tb_serial_bcd_correct;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bcd_correct_if bus();

  logic x_b = 1'b0;
  logic y_b = 1'b0;
  logic y_eff;

  assign y_eff      = bus.add_en & (y_b ^ bus.sub);
  assign bus.fa_sum = x_b ^ y_eff ^ bus.fa_ci;
  assign bus.fa_co  = (x_b & y_eff) | (x_b & bus.fa_ci) | (y_eff & bus.fa_ci);

  serial_bcd_correct #(.Digits(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic res_log   [0:127];
  logic ci_log    [0:127];
  logic carry_log [0:127];

  typedef struct {
    logic [55:0] x;
    logic [55:0] y;
    logic [13:0] mask;
    logic        sub;
    logic [55:0] exp_res;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [10];
  logic model_carry;

  task automatic check(input string name, input logic [55:0] got, input logic [55:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Decimal reference: digit-wise add or ten's-complement subtract over the window.
  function automatic logic [56:0] ref_model(input logic [55:0] x, input logic [55:0] y,
                                            input logic [13:0] m, input logic s, input logic cin);
    logic [55:0] r;
    logic        cf;
    int          c, xd, yd, t;
    bit          prev;
    r = '0; cf = cin; c = 0; prev = 0;
    for (int d = 0; d < 14; d++) begin
      xd = int'(x[4*d +: 4]);
      yd = int'(y[4*d +: 4]);
      if (m[d]) begin
        if (!prev) c = s ? 1 : 0;
        if (!s) begin
          t = xd + yd + c;
          c = (t >= 10) ? 1 : 0;
          r[4*d +: 4] = 4'(t % 10);
        end else begin
          t = xd - yd - 1 + c;
          if (t < 0) begin t = t + 10; c = 0; end
          else c = 1;
          r[4*d +: 4] = 4'(t);
        end
        cf = (c != 0);
        prev = 1;
      end else begin
        r[4*d +: 4] = x[4*d +: 4];
        prev = 0;
      end
    end
    return {cf, r};
  endfunction

  task automatic drive_word(input logic [55:0] x, input logic [55:0] y, input logic [13:0] mask,
                            input logic s, input int nbits, input int sync_at, input int base);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      res_log[base+i]   = bus.res_bit;
      carry_log[base+i] = bus.carry;
      x_b      = x[i];
      y_b      = y[i];
      bus.ws   = mask[i/4];
      bus.sub  = s;
      bus.sync = (i == sync_at);
      #1 ci_log[base+i] = bus.fa_ci;
    end
  endtask

  task automatic run_test(input string name, input logic [55:0] x, input logic [55:0] y,
                          input logic [13:0] mask, input logic s,
                          input logic [55:0] exp_res, input logic exp_carry);
    logic [55:0] got;
    drive_word(x, y, mask, s, 56, 55, 0);
    drive_word('0, '0, '0, 1'b0, 56, 55, 56);
    for (int j = 0; j < 56; j++) got[j] = res_log[j+4];
    check({name, " res"}, got, exp_res);
    check({name, " carry"}, {55'd0, carry_log[111]}, {55'd0, exp_carry});
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst      = 1'b0;
    bus.sync = 1'b1;
    bus.ws   = 1'b0;
    bus.sub  = 1'b0;
    x_b      = 1'b0;
    y_b      = 1'b0;
  endtask

  initial begin
    logic [55:0] rx, ry;
    logic [13:0] rm;
    logic        rs;
    logic [56:0] exp;
    int          first;
    string       nm;

    bus.sync = 1'b0;
    bus.ws   = 1'b0;
    bus.sub  = 1'b0;

    vecs[0] = '{56'h27, 56'h15, 14'h3FFF, 1'b0, 56'h42, 1'b0};
    vecs[1] = '{56'h99999999999999, 56'h1, 14'h3FFF, 1'b0, 56'h0, 1'b1};
    vecs[2] = '{56'h42, 56'h15, 14'h3FFF, 1'b1, 56'h27, 1'b1};
    vecs[3] = '{56'h15, 56'h42, 14'h3FFF, 1'b1, 56'h99999999999973, 1'b0};
    vecs[4] = '{56'h12345678901234, 56'h99900, 14'h001C, 1'b0, 56'h12345678901134, 1'b1};
    vecs[5] = '{56'h12345678901234, 56'h99900, 14'h001C, 1'b1, 56'h12345678901334, 1'b0};
    vecs[6] = '{56'h99, 56'h99, 14'h3FFF, 1'b0, 56'h198, 1'b0};
    vecs[7] = '{56'h99, 56'h99, 14'h0003, 1'b0, 56'h98, 1'b1};
    vecs[8] = '{56'h5, 56'h4, 14'h0001, 1'b0, 56'h9, 1'b0};
    vecs[9] = '{56'h5, 56'h5, 14'h0001, 1'b0, 56'h0, 1'b1};

    // Reset state.
    @(negedge clk);
    check("reset res_bit", {55'd0, bus.res_bit}, 56'd0);
    check("reset carry",   {55'd0, bus.carry},   56'd0);
    check("reset fa_ci",   {55'd0, bus.fa_ci},   56'd0);
    check("reset add_en",  {55'd0, bus.add_en},  56'd0);
    release_reset();

    // Directed vectors, with carry-in checked at the first in-window digit.
    for (int k = 0; k < 10; k++) begin
      nm = $sformatf("vec%0d", k);
      run_test(nm, vecs[k].x, vecs[k].y, vecs[k].mask, vecs[k].sub,
               vecs[k].exp_res, vecs[k].exp_carry);
      first = 0;
      for (int d = 13; d >= 0; d--) if (vecs[k].mask[d]) first = d;
      check({nm, " ci_start"}, {55'd0, ci_log[4*first]}, {55'd0, vecs[k].sub});
      model_carry = vecs[k].exp_carry;
    end

    // Random words against the decimal reference.
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 14; d++) begin
        rx[4*d +: 4] = 4'($urandom_range(0, 9));
        ry[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rm  = 14'($urandom_range(0, 16383));
      rs  = 1'($urandom_range(0, 1));
      exp = ref_model(rx, ry, rm, rs, model_carry);
      run_test($sformatf("rand%0d", n), rx, ry, rm, rs, exp[55:0], exp[56]);
      model_carry = exp[56];
    end

    // Asynchronous reset at bit 21 of an add in progress.
    drive_word(56'h99999999999999, 56'h77777777777777, 14'h3FFF, 1'b0, 21, -1, 0);
    @(negedge clk);
    check("pre_rst res_bit", {55'd0, bus.res_bit}, 56'd1);
    check("pre_rst carry",   {55'd0, bus.carry},   56'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst res_bit", {55'd0, bus.res_bit}, 56'd0);
    check("async_rst carry",   {55'd0, bus.carry},   56'd0);
    @(negedge clk);
    @(negedge clk);
    release_reset();
    run_test("post_rst", 56'h27, 56'h15, 14'h3FFF, 1'b0, 56'h42, 1'b0);

    // Sync at bit 30 (mid-digit): realign, next word starts a fresh window.
    drive_word(56'h27, 56'h15, 14'h3FFF, 1'b0, 31, 30, 0);
    run_test("resync", 56'h42, 56'h15, 14'h3FFF, 1'b1, 56'h27, 1'b1);
    check("resync ci_start", {55'd0, ci_log[0]}, 56'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
